// File: rtl/booth_disp_pkg.sv
// Shared types, constants and the BCD-to-segment decoder for the product display.
package booth_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } disp_state_t;

    localparam int BCD_W      = 20;
    localparam int BCD_DIGITS = 5;

    localparam logic [6:0] SEG_BLANK    = 7'h7F;
    localparam logic [6:0] SEG_MINUS    = 7'h3F;
    localparam logic [3:0] NIBBLE_BLANK = 4'hF;

    // Active-low cathodes, bit 0 = segment A; non-decimal codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/product_display_if.sv
// Result handshake between the multiplier (master) and the product display (slave).
interface product_display_if;

    logic signed [15:0] product;
    logic               done;
    logic               busy;
    logic               value_valid;

    modport master (
        output product,
        output done,
        input  busy,
        input  value_valid
    );

    modport slave (
        input  product,
        input  done,
        output busy,
        output value_valid
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 16-bit magnitude to 5 BCD digits in 16 cycles.
module bin2bcd_seq
    import booth_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      mag,
    output logic [BCD_W-1:0] bcd,
    output logic             finish
);

    logic [15:0]      shift_reg;
    logic [3:0]       iter_cnt;
    logic             running;
    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // High during the cycle whose closing edge performs the 16th shift.
    assign finish = running && (iter_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd       <= '0;
            iter_cnt  <= '0;
            running   <= 1'b0;
        end else if (start) begin
            shift_reg <= mag;
            bcd       <= '0;
            iter_cnt  <= '0;
            running   <= 1'b1;
        end else if (running) begin
            {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
            iter_cnt         <= iter_cnt + 4'd1;
            if (iter_cnt == 4'd15) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/product_display.sv
// Signed product to sign + 5 BCD digits on an 8-digit multiplexed 7-segment display.
// Define DISP_ZERO_BLANK_EN to blank leading zeros and float the minus sign.
module product_display
    import booth_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    product_display_if.slave    bus,
    output logic [7:0]          AN,
    output logic [6:0]          SEG,
    output logic                DP
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    disp_state_t      state, state_next;
    logic             start;
    logic [15:0]      start_val;
    logic [15:0]      start_mag;
    logic             conv_finish;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_sign;

    logic             pending_flag;
    logic [15:0]      pending_val;

    logic [BCD_W-1:0] disp_digits;
    logic             disp_sign;
    logic             value_valid_q;

    logic [CNT_W-1:0] refresh_cnt;
    logic [2:0]       scan_idx;
    logic [3:0]       cur_nibble;
    logic [6:0]       slot_seg;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A buffered request always wins over a fresh strobe so the latest value is never skipped.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        start_val  = bus.product;
        case (state)
            IDLE: begin
                if (pending_flag) begin
                    start      = 1'b1;
                    start_val  = pending_val;
                    state_next = CONV;
                end else if (bus.done) begin
                    start      = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_finish) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign start_mag = start_val[15] ? (~start_val + 16'd1) : start_val;

    bin2bcd_seq u_bin2bcd (
        .clk    (CLK100MHZ),
        .rst_n  (reset),
        .start  (start),
        .mag    (start_mag),
        .bcd    (conv_bcd),
        .finish (conv_finish)
    );

    // A strobe that cannot start right now is parked; a newer one overwrites it.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            pending_flag <= 1'b0;
            pending_val  <= '0;
        end else if (bus.done && ((state != IDLE) || pending_flag)) begin
            pending_flag <= 1'b1;
            pending_val  <= bus.product;
        end else if ((state == IDLE) && pending_flag) begin
            pending_flag <= 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            conv_sign     <= 1'b0;
            disp_digits   <= {BCD_DIGITS{NIBBLE_BLANK}};
            disp_sign     <= 1'b0;
            value_valid_q <= 1'b0;
        end else begin
            if (start) begin
                conv_sign <= start_val[15];
            end
            if (state == COMMIT) begin
                disp_digits   <= conv_bcd;
                disp_sign     <= conv_sign;
                value_valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.value_valid = value_valid_q;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        cur_nibble = NIBBLE_BLANK;
        case (scan_idx)
            3'd0:    cur_nibble = disp_digits[3:0];
            3'd1:    cur_nibble = disp_digits[7:4];
            3'd2:    cur_nibble = disp_digits[11:8];
            3'd3:    cur_nibble = disp_digits[15:12];
            3'd4:    cur_nibble = disp_digits[19:16];
            default: cur_nibble = NIBBLE_BLANK;
        endcase
    end

`ifdef DISP_ZERO_BLANK_EN
    logic [2:0] msd;

    // The most significant non-zero digit bounds what is shown; digit 0 is always shown.
    always_comb begin
        msd      = 3'd0;
        slot_seg = SEG_BLANK;
        for (int i = 1; i < BCD_DIGITS; i++) begin
            if (disp_digits[4*i +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
        if (scan_idx <= msd) begin
            slot_seg = bcd_to_seg(cur_nibble);
        end else if ((scan_idx == msd + 3'd1) && disp_sign) begin
            slot_seg = SEG_MINUS;
        end
    end
`else
    always_comb begin
        slot_seg = SEG_BLANK;
        if (scan_idx < 3'd5) begin
            slot_seg = bcd_to_seg(cur_nibble);
        end else if ((scan_idx == 3'd5) && disp_sign) begin
            slot_seg = SEG_MINUS;
        end
    end
`endif

    // Anode and cathode share one register stage so a slot never shows its neighbour's pattern.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            AN  <= 8'hFF;
            SEG <= SEG_BLANK;
        end else begin
            AN  <= ~(8'd1 << scan_idx);
            SEG <= slot_seg;
        end
    end

    assign DP = 1'b1;

endmodule

// File: tb/tb_product_display.sv
// Self-checking bench for product_display against an arithmetic decimal-display model.
module tb_product_display;

    localparam int REFRESH_DIV = 4;
    localparam int SCAN_SPAN   = 8 * REFRESH_DIV + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] cap_seg  [8];
    logic       cap_seen [8];

    product_display_if bus ();

    product_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .CLK100MHZ (clk),
        .reset     (rst_n),
        .bus       (bus),
        .AN        (an),
        .SEG       (seg),
        .DP        (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected cathodes for one slot once a signed value has been committed.
    function automatic logic [6:0] model_slot(input int value, input int slot);
        int mag;
        int pw;
        int ndig;
        int t;
        bit neg;
        neg = (value < 0);
        mag = neg ? -value : value;
        pw  = 1;
        for (int i = 0; i < slot; i++) pw = pw * 10;
        ndig = 1;
        t    = mag / 10;
        while (t > 0) begin
            ndig++;
            t = t / 10;
        end
`ifdef DISP_ZERO_BLANK_EN
        if (slot < ndig) return digit_seg((mag / pw) % 10);
        if ((slot == ndig) && neg) return 7'h3F;
        return 7'h7F;
`else
        if (slot < 5) return digit_seg((mag / pw) % 10);
        if ((slot == 5) && neg) return 7'h3F;
        return 7'h7F;
`endif
    endfunction

    task automatic capture_slots();
        for (int s = 0; s < 8; s++) begin
            cap_seg[s]  = 7'h7F;
            cap_seen[s] = 1'b0;
        end
        for (int c = 0; c < SCAN_SPAN; c++) begin
            @(negedge clk);
            for (int s = 0; s < 8; s++) begin
                if (an == ~(8'd1 << s)) begin
                    cap_seg[s]  = seg;
                    cap_seen[s] = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        rst_n    = 1'b0;
        bus.done = 1'b0;
        bus.product = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (an !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_an: got %h expected ff", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("[TB] FAIL reset_seg: got %h expected 7f", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.value_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.value_valid); end
        rst_n = 1'b1;
        for (int k = 1; k <= 8 * REFRESH_DIV + 4; k++) begin
            @(negedge clk);
            exp_an = ~(8'd1 << (((k - 1) / REFRESH_DIV) % 8));
            n_checks++; if (an !== exp_an) begin n_fail++; $display("[TB] FAIL scan_an k=%0d: got %h expected %h", k, an, exp_an); end
            n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("[TB] FAIL scan_blank k=%0d: got %h expected 7f", k, seg); end
        end
    endtask

    task automatic test_convert(input int value, input string name);
        int low_cycles;
        @(negedge clk);
        bus.product = 16'(value);
        bus.done    = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL %s busy_rise: got %b expected 1", name, bus.busy); end
        low_cycles = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) low_cycles++;
        end
        n_checks++; if (low_cycles != 0) begin n_fail++; $display("[TB] FAIL %s busy_window: got %0d low cycles expected 0", name, low_cycles); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL %s busy_fall: got %b expected 0", name, bus.busy); end
        n_checks++; if (bus.value_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL %s value_valid: got %b expected 1", name, bus.value_valid); end
        capture_slots();
        for (int s = 0; s < 8; s++) begin
            n_checks++;
            if (!cap_seen[s] || cap_seg[s] !== model_slot(value, s)) begin
                n_fail++;
                $display("[TB] FAIL %s slot%0d: got %h (seen %b) expected %h", name, s, cap_seg[s], cap_seen[s], model_slot(value, s));
            end
        end
    endtask

    task automatic test_minus7();
        logic [6:0] exp_slot [8];
        test_convert(-7, "minus7");
`ifdef DISP_ZERO_BLANK_EN
        exp_slot = '{7'h78, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_slot = '{7'h78, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F};
`endif
        for (int s = 0; s < 8; s++) begin
            n_checks++;
            if (cap_seg[s] !== exp_slot[s]) begin
                n_fail++;
                $display("[TB] FAIL minus7_layout slot%0d: got %h expected %h", s, cap_seg[s], exp_slot[s]);
            end
        end
    endtask

    // Three strobes at chosen cycles; only the first and the last should ever be committed.
    task automatic test_pending(input string name, input int c2, input int v1, input int v2, input int v3, input int c3);
        int falls;
        int fall_at [2];
        logic prev;
        falls   = 0;
        fall_at = '{-1, -1};
        prev    = bus.busy;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (prev && !bus.busy) begin
                if (falls < 2) fall_at[falls] = c;
                falls++;
            end
            if (c == 19) begin
                n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL %s restart: got %b expected 1", name, bus.busy); end
            end
            prev     = bus.busy;
            bus.done = 1'b0;
            if (c == 0)  begin bus.product = 16'(v1); bus.done = 1'b1; end
            if (c == c2) begin bus.product = 16'(v2); bus.done = 1'b1; end
            if (c == c3) begin bus.product = 16'(v3); bus.done = 1'b1; end
        end
        n_checks++; if (falls != 2) begin n_fail++; $display("[TB] FAIL %s commit_count: got %0d expected 2", name, falls); end
        n_checks++; if (fall_at[0] != 18) begin n_fail++; $display("[TB] FAIL %s first_commit: got %0d expected 18", name, fall_at[0]); end
        n_checks++; if (fall_at[1] != 36) begin n_fail++; $display("[TB] FAIL %s second_commit: got %0d expected 36", name, fall_at[1]); end
        capture_slots();
        for (int s = 0; s < 8; s++) begin
            n_checks++;
            if (cap_seg[s] !== model_slot(v3, s)) begin
                n_fail++;
                $display("[TB] FAIL %s slot%0d: got %h expected %h", name, s, cap_seg[s], model_slot(v3, s));
            end
        end
    endtask

    task automatic test_back_to_back();
        test_pending("back_to_back", 5, 100, 200, 300, 12);
    endtask

    task automatic test_done_at_commit();
        logic [15:0] r1;
        logic [15:0] r2;
        r1 = 16'($urandom);
        r2 = 16'($urandom);
        test_pending("done_at_commit", 17, int'($signed(r1)), int'($signed(r1)), int'($signed(r2)), 17);
    endtask

    task automatic test_reset_mid_conv();
        int bad_busy;
        int bad_valid;
        @(negedge clk);
        bus.product = 16'(-1234);
        bus.done    = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        bus.product = 16'(555);
        bus.done    = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (an !== 8'hFF) begin n_fail++; $display("[TB] FAIL midreset_an: got %h expected ff", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("[TB] FAIL midreset_seg: got %h expected 7f", seg); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.value_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %b expected 0", bus.value_valid); end
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bad_busy  = 0;
        bad_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad_busy++;
            if (bus.value_valid !== 1'b0) bad_valid++;
        end
        n_checks++; if (bad_busy != 0) begin n_fail++; $display("[TB] FAIL midreset_no_restart: got %0d busy cycles expected 0", bad_busy); end
        n_checks++; if (bad_valid != 0) begin n_fail++; $display("[TB] FAIL midreset_no_commit: got %0d valid cycles expected 0", bad_valid); end
        capture_slots();
        for (int s = 0; s < 8; s++) begin
            n_checks++;
            if (cap_seg[s] !== 7'h7F) begin
                n_fail++;
                $display("[TB] FAIL midreset_blank slot%0d: got %h expected 7f", s, cap_seg[s]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom);
            test_convert(int'($signed(r)), $sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_convert(391, "p391");
        test_convert(-16256, "n16256");
        test_convert(-32768, "min_neg");
        test_convert(32767, "max_pos");
        test_convert(0, "zero");
        test_minus7();
        test_random();
        test_back_to_back();
        test_done_at_commit();
        test_reset_mid_conv();
        test_convert(-4096, "after_reset");
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("[TB] FAIL dp_const: got %b expected 1", dp); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_display.md
Name: product_display

Overview:
- Consumer end of the multiplier's result handshake: accepts the signed 16-bit product plus the one-cycle `done` strobe.
- Converts the value to sign + 5 BCD digits with a sequential double-dabble engine.
- Drives the board's 8-digit multiplexed 7-segment display.
- Sits beside the multiplier in the top level, fed directly by `Mult`/`done`.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); must be ≥2.

Ports:
- CLK100MHZ  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- product  input  16  signed two's-complement product
- done  input  1  one-cycle strobe: product valid this cycle
- busy  output  1  conversion in progress
- value_valid  output  1  display holds a converted value
- AN  output  8  digit anodes, active-low, AN[0] = rightmost
- SEG  output  7  cathodes CA..CG = SEG[0]..SEG[6], active-low
- DP  output  1  decimal point, active-low, constant 1

Behaviour:
- Reset (async assert, sync release):
  - AN=8'hFF, SEG=7'h7F, DP=1, busy=0, value_valid=0.
  - Scan index 0, refresh counter 0, FSM IDLE, pending flag cleared, display digit regs all BLANK.
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - If the pending flag is set: load the pending value, clear the flag, go to CONV.
  - Else if done=1: load product, go to CONV.
  - Load means: sign = product[15]; mag = sign ? -product : product, as a 16-bit unsigned (16'h8000 → 32768); BCD reg = 0; iteration count = 0; busy=1 from this edge.
- CONV:
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left 1.
  - Exactly 16 iterations, then go to COMMIT.
- COMMIT:
  - Copy 5 BCD nibbles and sign into display regs; value_valid=1 (sticky until reset); busy=0; go to IDLE.
- Latency: done sampled at edge N → busy=1 after N, display regs updated at edge N+17, busy=0 after N+17. Next start no earlier than N+18.
- Buffering:
  - done=1 while busy (including the COMMIT edge) writes product into a one-deep pending reg and sets the flag.
  - A newer done overwrites an older pending value (latest wins).
  - done=1 in IDLE with the flag clear starts directly; the pending path is not used.
- Display layout:
  - digits 0..4 = ones..ten-thousands.
  - digit 5 = minus (SEG=7'b0111111) if sign, else blank.
  - digits 6, 7 = blank.
  - Before the first value_valid, all slots blank.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index increments mod 8.
  - AN and SEG are registered together: AN = ~(1<<index), SEG = encoding of the slot. No ghosting cycle between them.
  - Scanning runs regardless of busy; display regs change only at COMMIT.
- Reset mid-CONV: the conversion is abandoned, nothing is committed, and the pending value is lost.

Optional Feature:
- DISP_ZERO_BLANK_EN defined:
  - Leading zeros in digits 4..1 are blanked; digit 0 is always shown.
  - The minus sign occupies the slot immediately left of the most significant shown digit.
  - Example: -7 → digit1 minus, digit0 7, rest blank.
- Not defined: fixed layout as above (-7 → "-00007" across digits 5..0).

Decomposition:
- Shared package booth_disp_pkg holds:
  - state enum {IDLE, CONV, COMMIT}
  - constants SEG_BLANK=7'h7F, SEG_MINUS=7'h3F
  - a function mapping a 4-bit BCD nibble to its active-low 7-segment code
  - BCD width constant 20
- Sub-module bin2bcd_seq: the double-dabble engine.
  - Inputs: start, mag[15:0].
  - Outputs: bcd[19:0], finish.
  - Exactly 16 cycles.
  - Instantiated once; the parent owns FSM, pending buffer, scan logic.

Test Plan (REFRESH_DIV=4 unless stated):
- Reset held low → AN=FF, SEG=7F, DP=1, busy=0, value_valid=0. Release → AN cycles FE,FD,…,7F every 4 clocks with SEG=7F in all slots.
- product=391, done pulse at edge N → busy high for 17 cycles; after N+17, slots 0..5 show 1,9,3,0,0,blank. Slot 0 SEG=7'b1111001.
- product=-16256 (-128×127) → slots 0..4 = 6,5,2,6,1; slot 5 SEG=7'b0111111.
- product=16'h8000 → slots 0..4 = 8,6,7,2,3; minus in slot 5 (magnitude boundary).
- done with 100, then 200 and 300 during its conversion → display shows 100, then 300; 200 never committed. busy stays low only after the 300 commit.
- Reset asserted at cycle 8 of a conversion → outputs at reset values immediately, value_valid stays 0, no later commit. Repeat the -7 case with and without DISP_ZERO_BLANK_EN and check both layouts.
